// File: rtl/snake_head_stepper_pkg.sv
// Shared definitions for the snake head stepper: direction codes, default grid size
// and the reversal test used by the direction guard.
`default_nettype none

package snake_head_stepper_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_UP    = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // Grid size shared with the navigation FSM and the display stage.
  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;

  // Opposite directions are encoded as bitwise complements.
  function automatic logic is_reverse(input dir_t req, input dir_t cur);
    return req == ~cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_head_stepper_prescaler.sv
// step_prescaler: counts enabled cycles 0..STEP_DIV-1 and flags the terminal cycle.
`default_nettype none

module step_prescaler #(
  parameter int STEP_DIV = 2500000,
  parameter int CNT_W    = 22
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(STEP_DIV - 1));
  assign TICK   = ENABLE && w_last;

  // The count is frozen, not cleared, while ENABLE is low.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (ENABLE) begin
      if (w_last) r_cnt <= '0;
      else        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: advances the snake head one cell per game tick with reversal guard
// and edge wrap; defining WALL_STOP_EN turns edge moves into a sticky CRASH instead.
`default_nettype none

module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int STEP_DIV = 2500000,
  parameter int CNT_W    = 22,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           ENABLE,
  input  logic [1:0]     DIR_IN,
  output logic [X_W-1:0] HEAD_X,
  output logic [Y_W-1:0] HEAD_Y,
  output logic [1:0]     DIR_OUT,
  output logic           STEP,
  output logic           CRASH
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  dir_t           r_dir;
  logic           r_step;
  logic           r_crash;

  logic           w_tick;
  dir_t           w_dir;
  logic [X_W-1:0] w_nx;
  logic [Y_W-1:0] w_ny;
  logic           w_can_move;

  step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .TICK   (w_tick)
  );

  assign w_dir = is_reverse(DIR_IN, r_dir) ? r_dir : DIR_IN;

  // Edge cells are tested explicitly so the counters never run past the grid.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (w_dir)
      DIR_RIGHT: w_nx = (r_x == X_W'(GRID_W - 1)) ? '0 : r_x + X_W'(1);
      DIR_LEFT:  w_nx = (r_x == '0) ? X_W'(GRID_W - 1) : r_x - X_W'(1);
      DIR_DOWN:  w_ny = (r_y == Y_W'(GRID_H - 1)) ? '0 : r_y + Y_W'(1);
      default:   w_ny = (r_y == '0) ? Y_W'(GRID_H - 1) : r_y - Y_W'(1);
    endcase
  end

`ifdef WALL_STOP_EN
  logic w_hit_wall;

  always_comb begin
    w_hit_wall = 1'b0;
    case (w_dir)
      DIR_RIGHT: w_hit_wall = (r_x == X_W'(GRID_W - 1));
      DIR_LEFT:  w_hit_wall = (r_x == '0);
      DIR_DOWN:  w_hit_wall = (r_y == Y_W'(GRID_H - 1));
      default:   w_hit_wall = (r_y == '0);
    endcase
  end

  assign w_can_move = !r_crash && !w_hit_wall;

  always_ff @(posedge CLOCK) begin
    if (RESET)                                r_crash <= 1'b0;
    else if (w_tick && !r_crash && w_hit_wall) r_crash <= 1'b1;
  end
`else
  assign w_can_move = 1'b1;

  always_ff @(posedge CLOCK) begin
    r_crash <= 1'b0;
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_x    <= X_W'(START_X);
      r_y    <= Y_W'(START_Y);
      r_dir  <= DIR_RIGHT;
      r_step <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_tick && w_can_move) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_dir  <= w_dir;
        r_step <= 1'b1;
      end
    end
  end

  assign HEAD_X  = r_x;
  assign HEAD_Y  = r_y;
  assign DIR_OUT = r_dir;
  assign STEP    = r_step;
  assign CRASH   = r_crash;

endmodule

`default_nettype wire

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper on an 8x6 grid with a 4-cycle tick.
`default_nettype none

module tb_snake_head_stepper;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int SD = 4;
  localparam int SX = 4;
  localparam int SY = 3;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic [1:0] DIR_IN = 2'b00;
  logic [2:0] HEAD_X;
  logic [2:0] HEAD_Y;
  logic [1:0] DIR_OUT;
  logic       STEP;
  logic       CRASH;

  snake_head_stepper #(
    .GRID_W (GW), .GRID_H (GH), .X_W (3), .Y_W (3),
    .STEP_DIV (SD), .CNT_W (2), .START_X (SX), .START_Y (SY)
  ) dut (
    .CLOCK (CLOCK), .RESET (RESET), .ENABLE (ENABLE), .DIR_IN (DIR_IN),
    .HEAD_X (HEAD_X), .HEAD_Y (HEAD_Y), .DIR_OUT (DIR_OUT),
    .STEP (STEP), .CRASH (CRASH)
  );

  always #5 CLOCK = ~CLOCK;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: head position as plain integers on a torus.
  int m_phase, m_x, m_y, m_dir, m_step;

  typedef struct {
    logic rst; logic en; logic [1:0] dir;
    int step; int x; int y; int dout;
  } vec_t;
  vec_t tbl[$];
  int   cur_x, cur_y, cur_d;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [1:0] d);
    int req;
    if (rst) begin
      m_phase = 0; m_x = SX; m_y = SY; m_dir = 0; m_step = 0;
    end else if (!en) begin
      m_step = 0;
    end else begin
      m_step  = (m_phase == SD - 1) ? 1 : 0;
      m_phase = (m_phase + 1) % SD;
      if (m_step == 1) begin
        req = int'(d);
        if ((req ^ m_dir) != 3) m_dir = req;
        case (m_dir)
          0: m_x = (m_x + 1) % GW;
          3: m_x = (m_x + GW - 1) % GW;
          1: m_y = (m_y + 1) % GH;
          default: m_y = (m_y + GH - 1) % GH;
        endcase
      end
    end
  endtask

  task automatic apply(input logic rst, input logic en, input logic [1:0] d);
    RESET = rst; ENABLE = en; DIR_IN = d;
    @(posedge CLOCK);
    model_step(rst, en, d);
    #1;
    check("model_step", int'(STEP), m_step);
    check("model_x", int'(HEAD_X), m_x);
    check("model_y", int'(HEAD_Y), m_y);
    check("model_dir", int'(DIR_OUT), m_dir);
    check("model_crash", int'(CRASH), 0);
  endtask

  // One game tick of SD enabled cycles; the last one carries the step and new head.
  task automatic push_tick(input logic [1:0] d, input int ex, input int ey, input int ed);
    for (int i = 0; i < SD - 1; i++)
      tbl.push_back('{1'b0, 1'b1, d, 0, cur_x, cur_y, cur_d});
    tbl.push_back('{1'b0, 1'b1, d, 1, ex, ey, ed});
    cur_x = ex; cur_y = ey; cur_d = ed;
  endtask

  initial begin
    tbl.push_back('{1'b1, 1'b0, 2'b00, 0, SX, SY, 0});
    cur_x = SX; cur_y = SY; cur_d = 0;
    push_tick(2'b00, 5, 3, 0);
    push_tick(2'b00, 6, 3, 0);
    push_tick(2'b11, 7, 3, 0);   // reversal ignored
    push_tick(2'b01, 7, 4, 1);
    push_tick(2'b00, 0, 4, 0);   // right wrap
    push_tick(2'b10, 0, 3, 2);
    push_tick(2'b11, 7, 3, 3);   // left wrap
    push_tick(2'b10, 7, 2, 2);
    push_tick(2'b10, 7, 1, 2);
    push_tick(2'b10, 7, 0, 2);
    push_tick(2'b10, 7, 5, 2);   // up wrap
    push_tick(2'b01, 7, 4, 2);   // reversal ignored on Y

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].dir);
      check("tbl_step", int'(STEP), tbl[i].step);
      check("tbl_x", int'(HEAD_X), tbl[i].x);
      check("tbl_y", int'(HEAD_Y), tbl[i].y);
      check("tbl_dir", int'(DIR_OUT), tbl[i].dout);
    end

    // Pause at count 2 for ten cycles, then the step lands two cycles after resume.
    apply(1'b0, 1'b1, 2'b00);
    apply(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 2'b00);
      check("hold_step", int'(STEP), 0);
      check("hold_x", int'(HEAD_X), 7);
    end
    apply(1'b0, 1'b1, 2'b00);
    check("resume_early_step", int'(STEP), 0);
    apply(1'b0, 1'b1, 2'b00);
    check("resume_step", int'(STEP), 1);
    check("resume_x", int'(HEAD_X), 0);
    check("resume_y", int'(HEAD_Y), 4);

    // Reset on the terminal cycle must beat the pending step.
    for (int i = 0; i < SD - 1; i++) apply(1'b0, 1'b1, 2'b01);
    apply(1'b1, 1'b1, 2'b01);
    check("rst_term_step", int'(STEP), 0);
    check("rst_term_x", int'(HEAD_X), SX);
    check("rst_term_y", int'(HEAD_Y), SY);
    check("rst_term_dir", int'(DIR_OUT), 0);
    check("rst_term_crash", int'(CRASH), 0);

    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
